// File: rtl/output_port_arbiter.sv
// Round-robin wormhole arbiter for one router output port: grant is locked per packet, released on tail.
// Optional stall watchdog (forced release + wd_err pulse) enabled by defining OPA_WATCHDOG_EN.
module output_port_arbiter #(
  parameter int N_IN      = 5,
  parameter int WD_CYCLES = 64,
  parameter int PTR_W     = $clog2(N_IN)
) (
  input  logic            clk,
  input  logic            preset,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] flit_valid,
  input  logic [N_IN-1:0] tail,
  input  logic            out_ready,
  output logic [N_IN-1:0] grant,
  output logic            busy,
  output logic            xfer,
  output logic            wd_err
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state, state_n;
  logic [N_IN-1:0]    grant_n;
  logic [PTR_W-1:0]   ptr, ptr_n, owner, arb_ptr;
  logic [N_IN-1:0]    lane_xfer;
  logic [N_IN-1:0]    win_oh;
  logic               tail_rel, wd_fire, release_w;

  // Explicit wrap: N_IN need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_IN-1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    assign lane_xfer[i] = grant[i] & flit_valid[i];
  end

  assign xfer     = (|lane_xfer) & out_ready;
  assign busy     = (state == LOCK);
  assign tail_rel = xfer & (|(grant & tail));

  always_comb begin
    owner = '0;
    for (int i = 0; i < N_IN; i++)
      if (grant[i]) owner = PTR_W'(i);
  end

  // On a release the owner becomes the pointer, so it is last in the scan.
  assign arb_ptr = (state == LOCK) ? owner : ptr;

  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    win_oh = '0;
    found  = 1'b0;
    idx    = arb_ptr;
    for (int k = 0; k < N_IN; k++) begin
      idx = ptr_inc(idx);
      if (!found && req[idx]) begin
        win_oh[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    ptr_n     = ptr;
    release_w = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n = win_oh;
          state_n = LOCK;
        end
      end
      LOCK: begin
        release_w = tail_rel | wd_fire;
        if (release_w) begin
          ptr_n = owner;
          if (|req) begin
            grant_n = win_oh;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!preset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= PTR_W'(N_IN-1);
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end

`ifdef OPA_WATCHDOG_EN
  localparam int CNT_W = $clog2(WD_CYCLES+1);
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_err_q;
  logic             lock_entry;

  // Fires on the edge that completes the WD_CYCLES-th consecutive stalled cycle.
  assign wd_fire    = (state == LOCK) && !xfer && (wd_cnt == CNT_W'(WD_CYCLES-1));
  assign lock_entry = (state_n == LOCK) && ((state == IDLE) || release_w);

  always_ff @(posedge clk) begin
    if (!preset) begin
      wd_cnt   <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_err_q <= wd_fire;
      if (state != LOCK || xfer || lock_entry || release_w) wd_cnt <= '0;
      else                                                   wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

  a_wd_cfg: assert property (@(posedge clk) WD_CYCLES > 0);
  a_grant:  assert property (@(posedge clk) disable iff (!preset)
                             $onehot0(grant) && (busy == (|grant)));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: directed cycles push expected outputs, a negedge monitor compares.
module tb_output_port_arbiter;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         preset;
  logic [N-1:0] req, flit_valid, tail;
  logic         out_ready;
  logic [N-1:0] grant;
  logic         busy, xfer, wd_err;

  typedef struct {
    logic [N-1:0] g;
    logic         x;
    string        nm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  output_port_arbiter #(.N_IN(N), .WD_CYCLES(8)) dut (
    .clk        (clk),
    .preset     (preset),
    .req        (req),
    .flit_valid (flit_valid),
    .tail       (tail),
    .out_ready  (out_ready),
    .grant      (grant),
    .busy       (busy),
    .xfer       (xfer),
    .wd_err     (wd_err)
  );

  always #5 clk = ~clk;

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (grant !== e.g || busy !== (|e.g) || xfer !== e.x || wd_err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s: got grant=%b busy=%b xfer=%b wd_err=%b, want grant=%b busy=%b xfer=%b wd_err=0",
                 e.nm, grant, busy, xfer, wd_err, e.g, |e.g, e.x);
      end
    end
  end

  task automatic cyc(input logic rn, input logic [N-1:0] r, fv, tl, input logic rdy,
                     input logic [N-1:0] eg, input logic ex, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    preset = rn; req = r; flit_valid = fv; tail = tl; out_ready = rdy;
    e.g = eg; e.x = ex; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    preset = 1'b0; req = '0; flit_valid = '0; tail = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // 1: reset state, 1-cycle grant latency, single-flit tail hands over
    cyc(1, 5'b00101, 5'b00000, 5'b00000, 1, 5'b00000, 0, "t1_reset");
    cyc(1, 5'b00101, 5'b00000, 5'b00000, 1, 5'b00001, 0, "t1_grant0");
    cyc(1, 5'b00101, 5'b00001, 5'b00001, 1, 5'b00001, 1, "t1_tail0");
    // non-granted valid/tail ignored
    cyc(1, 5'b00000, 5'b11011, 5'b11011, 1, 5'b00100, 0, "t1_grant2_ignore");
    // 3: stall with out_ready=0 for 10 cycles
    for (int i = 0; i < 10; i++)
      cyc(1, 5'b00000, 5'b00100, 5'b00100, 0, 5'b00100, 0, "t3_stall");
    cyc(1, 5'b00000, 5'b00100, 5'b00100, 1, 5'b00100, 1, "t3_ready");
    cyc(1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, "t3_idle");
    // 2: reset ptr, then full rotation without bubbles
    cyc(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, "t2_rst");
    cyc(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00000, 0, "t2_req");
    cyc(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00001, 1, "t2_g0");
    cyc(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00010, 1, "t2_g1");
    cyc(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b00100, 1, "t2_g2");
    cyc(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b01000, 1, "t2_g3");
    cyc(1, 5'b11111, 5'b11111, 5'b11111, 1, 5'b10000, 1, "t2_g4");
    cyc(1, 5'b00000, 5'b11111, 5'b11111, 1, 5'b00001, 1, "t2_wrap0");
    cyc(1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, "t2_idle");
    // 4: 4-flit packet from input 3 while input 1 requests and shows a tail
    cyc(1, 5'b01000, 5'b00000, 5'b00000, 1, 5'b00000, 0, "t4_req3");
    cyc(1, 5'b01010, 5'b01010, 5'b00010, 1, 5'b01000, 1, "t4_f1");
    cyc(1, 5'b01010, 5'b01010, 5'b00010, 1, 5'b01000, 1, "t4_f2");
    cyc(1, 5'b01010, 5'b01010, 5'b00010, 0, 5'b01000, 0, "t4_hold");
    cyc(1, 5'b01010, 5'b01010, 5'b00010, 1, 5'b01000, 1, "t4_f3");
    cyc(1, 5'b01010, 5'b01010, 5'b01010, 1, 5'b01000, 1, "t4_tail");
    // 5: input 1 hands to 4; reset mid-packet clears grant and ptr
    cyc(1, 5'b10000, 5'b00010, 5'b00010, 1, 5'b00010, 1, "t4_after_tail");
    cyc(1, 5'b10001, 5'b10000, 5'b00000, 1, 5'b10000, 1, "t5_body4");
    cyc(0, 5'b10001, 5'b10000, 5'b00000, 1, 5'b10000, 1, "t5_rst_edge");
    cyc(1, 5'b10001, 5'b00000, 5'b00000, 1, 5'b00000, 0, "t5_cleared");
    cyc(1, 5'b10001, 5'b00000, 5'b00000, 1, 5'b00001, 0, "t5_g0");
    // 6: lock to input 1, stall with no valid and owner dropping req
    cyc(1, 5'b00010, 5'b00001, 5'b00001, 1, 5'b00001, 1, "t6_tail0");
    for (int i = 0; i < 12; i++)
      cyc(1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00010, 0, "t6_hold1");

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected records left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
